// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings, widths and request payload type for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned NUM_REQ = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_ACCESS  = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_DATA  = 2'd1;
    localparam logic [1:0] REQ_EXT   = 2'd2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_payload_t;

    // Next requester index in round-robin order, wrapping 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= REQ_EXT) ? REQ_FETCH : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick3.sv
// Three-way round-robin pick: first set request bit after LAST, wrapping.
module rr_pick3
    import mem_bus_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [1:0]         LAST,
    output logic               VALID,
    output logic [1:0]         WINNER
);

    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;

    assign first  = rr_next(LAST);
    assign second = rr_next(first);
    assign third  = rr_next(second);

    always_comb begin
        VALID  = |REQ;
        WINNER = third;
        if (REQ[first]) begin
            WINNER = first;
        end else if (REQ[second]) begin
            WINNER = second;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory address/data bus between three
// requesters; each transfer runs SETUP -> ACCESS x N -> RECOVER.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned DELAY_RISE    = 0,
    parameter int unsigned DELAY_FALL    = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] WE,
    input  logic [ADDR_W-1:0] ADDR_0,
    input  logic [ADDR_W-1:0] ADDR_1,
    input  logic [ADDR_W-1:0] ADDR_2,
    input  logic [DATA_W-1:0] WDATA_0,
    input  logic [DATA_W-1:0] WDATA_1,
    input  logic [DATA_W-1:0] WDATA_2,
    output logic [NUM_REQ-1:0] ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA_OUT,
    output logic              MEM_DATA_OE,
    input  logic [DATA_W-1:0] MEM_DATA_IN,
    output logic              MEM_OE_bar,
    output logic              MEM_WE_bar,
    output logic              BUSY,
    output logic [1:0]        GRANT_INDEX
);

    // Rise/fall delays describe board-level timing only; the registers here are zero-delay.
    if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_board_delay
    end

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         last_q;
    logic [1:0]         last_d;
    logic               we_q;
    logic               we_d;

    logic [NUM_REQ-1:0] ack_d;
    logic [DATA_W-1:0]  rdata_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  dout_d;
    logic               doe_d;
    logic               oe_bar_d;
    logic               we_bar_d;
    logic               busy_d;
    logic [1:0]         gidx_d;

    logic               pick_valid;
    logic [1:0]         pick_winner;
    req_payload_t       pick;

    rr_pick3 u_rr_pick3 (
        .REQ    (REQ),
        .LAST   (last_q),
        .VALID  (pick_valid),
        .WINNER (pick_winner)
    );

    // Payload of the requester that would win this cycle.
    always_comb begin
        pick = '0;
        case (pick_winner)
            REQ_FETCH: pick = '{we: WE[0], addr: ADDR_0, wdata: WDATA_0};
            REQ_DATA:  pick = '{we: WE[1], addr: ADDR_1, wdata: WDATA_1};
            default:   pick = '{we: WE[2], addr: ADDR_2, wdata: WDATA_2};
        endcase
    end

    // Next state and next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        we_d     = we_q;
        ack_d    = '0;
        rdata_d  = RDATA;
        addr_d   = MEM_ADDR;
        dout_d   = MEM_DATA_OUT;
        doe_d    = MEM_DATA_OE;
        oe_bar_d = 1'b1;
        we_bar_d = 1'b1;
        gidx_d   = GRANT_INDEX;

        case (state_q)
            ST_IDLE: begin
                doe_d = 1'b0;
                if (pick_valid) begin
                    state_d = ST_SETUP;
                    gidx_d  = pick_winner;
                    we_d    = pick.we;
                    addr_d  = pick.addr;
                    doe_d   = pick.we;
                    if (pick.we) begin
                        dout_d = pick.wdata;
                    end
                end
            end
            ST_SETUP: begin
                state_d  = ST_ACCESS;
                cnt_d    = CNT_W'(ACCESS_CYCLES - 1);
                oe_bar_d = we_q;
                we_bar_d = !we_q;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                    ack_d   = 3'b001 << GRANT_INDEX;
                    if (!we_q) begin
                        rdata_d = MEM_DATA_IN;
                    end
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    oe_bar_d = we_q;
                    we_bar_d = !we_q;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
                last_d  = GRANT_INDEX;
                doe_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                doe_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_q       <= REQ_EXT;
            we_q         <= 1'b0;
            ACK          <= '0;
            RDATA        <= '0;
            MEM_ADDR     <= '0;
            MEM_DATA_OUT <= '0;
            MEM_DATA_OE  <= 1'b0;
            MEM_OE_bar   <= 1'b1;
            MEM_WE_bar   <= 1'b1;
            BUSY         <= 1'b0;
            GRANT_INDEX  <= REQ_FETCH;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            we_q         <= we_d;
            ACK          <= ack_d;
            RDATA        <= rdata_d;
            MEM_ADDR     <= addr_d;
            MEM_DATA_OUT <= dout_d;
            MEM_DATA_OE  <= doe_d;
            MEM_OE_bar   <= oe_bar_d;
            MEM_WE_bar   <= we_bar_d;
            BUSY         <= busy_d;
            GRANT_INDEX  <= gidx_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle table plus multi-cycle sequences.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req, req1, req15, we;
    logic [15:0] addr_0, addr_1, addr_2;
    logic [7:0]  wdata_0, wdata_1, wdata_2, din;

    logic [2:0]  ack;
    logic [7:0]  rdata, mem_dout;
    logic [15:0] mem_addr;
    logic        mem_doe, oeb, web, busy;
    logic [1:0]  gidx;

    logic [2:0]  d1_ack, d15_ack;
    logic [7:0]  d1_rdata, d15_rdata, d1_dout, d15_dout;
    logic [15:0] d1_addr, d15_addr;
    logic        d1_doe, d15_doe, d1_oeb, d15_oeb, d1_web, d15_web, d1_busy, d15_busy;
    logic [1:0]  d1_gidx, d15_gidx;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    mem_bus_arbiter #(.ACCESS_CYCLES(2)) u_dut (
        .CLK(clk), .RST(rst), .REQ(req), .WE(we),
        .ADDR_0(addr_0), .ADDR_1(addr_1), .ADDR_2(addr_2),
        .WDATA_0(wdata_0), .WDATA_1(wdata_1), .WDATA_2(wdata_2),
        .ACK(ack), .RDATA(rdata), .MEM_ADDR(mem_addr), .MEM_DATA_OUT(mem_dout),
        .MEM_DATA_OE(mem_doe), .MEM_DATA_IN(din), .MEM_OE_bar(oeb), .MEM_WE_bar(web),
        .BUSY(busy), .GRANT_INDEX(gidx)
    );

    mem_bus_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
        .CLK(clk), .RST(rst), .REQ(req1), .WE(we),
        .ADDR_0(addr_0), .ADDR_1(addr_1), .ADDR_2(addr_2),
        .WDATA_0(wdata_0), .WDATA_1(wdata_1), .WDATA_2(wdata_2),
        .ACK(d1_ack), .RDATA(d1_rdata), .MEM_ADDR(d1_addr), .MEM_DATA_OUT(d1_dout),
        .MEM_DATA_OE(d1_doe), .MEM_DATA_IN(din), .MEM_OE_bar(d1_oeb), .MEM_WE_bar(d1_web),
        .BUSY(d1_busy), .GRANT_INDEX(d1_gidx)
    );

    mem_bus_arbiter #(.ACCESS_CYCLES(15)) u_dut15 (
        .CLK(clk), .RST(rst), .REQ(req15), .WE(we),
        .ADDR_0(addr_0), .ADDR_1(addr_1), .ADDR_2(addr_2),
        .WDATA_0(wdata_0), .WDATA_1(wdata_1), .WDATA_2(wdata_2),
        .ACK(d15_ack), .RDATA(d15_rdata), .MEM_ADDR(d15_addr), .MEM_DATA_OUT(d15_dout),
        .MEM_DATA_OE(d15_doe), .MEM_DATA_IN(din), .MEM_OE_bar(d15_oeb), .MEM_WE_bar(d15_web),
        .BUSY(d15_busy), .GRANT_INDEX(d15_gidx)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [2:0]  we;
        logic [7:0]  din;
        logic [2:0]  ack;
        logic [7:0]  rdata;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        doe;
        logic        oeb;
        logic        web;
        logic        busy;
        logic [1:0]  gidx;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst_i, input logic [2:0] req_i, we_i,
                                input logic [7:0] din_i, input logic [2:0] ack_i,
                                input logic [7:0] rd_i, input logic [15:0] ad_i,
                                input logic [7:0] do_i, input logic doe_i, oeb_i,
                                web_i, busy_i, input logic [1:0] g_i);
        vec_t v;
        v.rst = rst_i; v.req = req_i; v.we = we_i; v.din = din_i;
        v.ack = ack_i; v.rdata = rd_i; v.addr = ad_i; v.dout = do_i;
        v.doe = doe_i; v.oeb = oeb_i; v.web = web_i; v.busy = busy_i; v.gidx = g_i;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Step edges until an ACK appears on the main DUT; a is 0 if the bound expires.
    task automatic wait_ack(output logic [2:0] a, output int n);
        n = 0;
        a = '0;
        while (n < 40 && a == 3'b000) begin
            @(posedge clk); #1;
            n++;
            a = ack;
        end
    endtask

    // Single read by requester 2 on the ACCESS_CYCLES=1 (big=0) or =15 (big=1) instance.
    task automatic run_latency(input bit big, input int ac);
        int          n;
        int          low;
        logic [2:0]  a;
        logic [7:0]  rd;
        logic [7:0]  exp_rd;
        exp_rd = big ? 8'hC3 : 8'h5A;
        din = exp_rd;
        if (big) req15 = 3'b100; else req1 = 3'b100;
        @(posedge clk); #1;
        req1 = 3'b000;
        req15 = 3'b000;
        n = 0; low = 0; a = '0; rd = '0;
        if ((big ? d15_oeb : d1_oeb) == 1'b0) low++;
        while (n < 40 && a == 3'b000) begin
            @(posedge clk); #1;
            n++;
            if ((big ? d15_oeb : d1_oeb) == 1'b0) low++;
            a  = big ? d15_ack : d1_ack;
            rd = big ? d15_rdata : d1_rdata;
        end
        check($sformatf("lat_ack_ac%0d", ac), 64'(a), 64'(3'b100));
        check($sformatf("lat_edges_ac%0d", ac), 64'(n), 64'(ac + 1));
        check($sformatf("lat_strobe_ac%0d", ac), 64'(low), 64'(ac));
        check($sformatf("lat_rdata_ac%0d", ac), 64'(rd), 64'(exp_rd));
        @(posedge clk); #1;
    endtask

    // Bus-level invariants on the main instance every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(ack) > 1 || (!oeb && !web)) begin
                errors++;
                $display("FAIL bus_exclusive: ack=%b oe_bar=%b we_bar=%b", ack, oeb, web);
            end
        end
    end

    logic [2:0] a;
    logic [2:0] exp3;
    int         n;

    initial begin
        rst = 1'b1; req = '0; req1 = '0; req15 = '0; we = '0;
        addr_0 = 16'h1234; addr_1 = 16'h8001; addr_2 = 16'h0F0F;
        wdata_0 = 8'h11; wdata_1 = 8'h3C; wdata_2 = 8'h99; din = 8'h00;

        //             rst   req     we      din    ack     rdata  addr      dout   doe   oeb   web   busy  gidx
        vecs[0]  = mk(1'b1, 3'b000, 3'b000, 8'hA5, 3'b000, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        vecs[1]  = mk(1'b0, 3'b001, 3'b000, 8'hA5, 3'b000, 8'h00, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        vecs[2]  = mk(1'b0, 3'b000, 3'b000, 8'hA5, 3'b000, 8'h00, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        vecs[3]  = mk(1'b0, 3'b000, 3'b000, 8'hA5, 3'b000, 8'h00, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        vecs[4]  = mk(1'b0, 3'b000, 3'b000, 8'hA5, 3'b001, 8'hA5, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        vecs[5]  = mk(1'b0, 3'b010, 3'b010, 8'h77, 3'b000, 8'hA5, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        vecs[6]  = mk(1'b0, 3'b010, 3'b010, 8'h77, 3'b000, 8'hA5, 16'h8001, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
        vecs[7]  = mk(1'b0, 3'b000, 3'b010, 8'h77, 3'b000, 8'hA5, 16'h8001, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        vecs[8]  = mk(1'b0, 3'b000, 3'b010, 8'h77, 3'b000, 8'hA5, 16'h8001, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        vecs[9]  = mk(1'b0, 3'b000, 3'b010, 8'h77, 3'b010, 8'hA5, 16'h8001, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
        vecs[10] = mk(1'b0, 3'b000, 3'b010, 8'h77, 3'b000, 8'hA5, 16'h8001, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);

        // Reset, one read by requester 0, one write by requester 1.
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; req = vecs[i].req; we = vecs[i].we; din = vecs[i].din;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  64'({ack, rdata, mem_addr, mem_dout, mem_doe, oeb, web, busy, gidx}),
                  64'({vecs[i].ack, vecs[i].rdata, vecs[i].addr, vecs[i].dout,
                       vecs[i].doe, vecs[i].oeb, vecs[i].web, vecs[i].busy, vecs[i].gidx}));
            mon_en = 1'b1;
        end

        // All three requesting continuously after a fresh reset.
        rst = 1'b1; req = '0; we = '0;
        @(posedge clk); #1;
        rst = 1'b0; req = 3'b111;
        for (int t = 0; t < 6; t++) begin
            wait_ack(a, n);
            exp3 = 3'(1 << (t % 3));
            check($sformatf("rr_grant%0d", t), 64'(a), 64'(exp3));
            check($sformatf("rr_spacing%0d", t), 64'(n), 64'(4));
            if (t == 5) req = 3'b101;
            @(posedge clk); #1;
            check($sformatf("rr_idle%0d", t), 64'({busy, ack}), 64'(0));
        end

        // Requester 0 re-requests at once; requester 2 must still get in next.
        wait_ack(a, n);
        check("starve_first", 64'(a), 64'(3'b001));
        @(posedge clk); #1;
        wait_ack(a, n);
        check("starve_ext", 64'(a), 64'(3'b100));
        req = 3'b000;
        @(posedge clk); #1;

        // Move the round-robin pointer to 0 before the abort test.
        req = 3'b001;
        wait_ack(a, n);
        check("prep_read", 64'(a), 64'(3'b001));
        req = 3'b000;
        @(posedge clk); #1;

        // Write by requester 1 aborted by reset in its first ACCESS cycle.
        req = 3'b010; we = 3'b010;
        @(posedge clk); #1;
        check("abort_setup", 64'({mem_doe, busy, gidx}), 64'({1'b1, 1'b1, 2'd1}));
        req = 3'b000;
        @(posedge clk); #1;
        check("abort_access", 64'({web, oeb}), 64'({1'b0, 1'b1}));
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_reset", 64'({ack, web, oeb, mem_doe, busy, gidx}),
              64'({3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("abort_noack%0d", i), 64'({ack, busy}), 64'(0));
        end
        req = 3'b111; we = 3'b000;
        @(posedge clk); #1;
        check("abort_regrant", 64'({busy, gidx}), 64'({1'b1, 2'd0}));
        req = 3'b000;
        wait_ack(a, n);
        check("abort_regrant_ack", 64'(a), 64'(3'b001));
        @(posedge clk); #1;

        // Strobe width and ACK latency at the extremes of ACCESS_CYCLES.
        run_latency(1'b0, 1);
        run_latency(1'b1, 15);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit memory address bus and 8-bit memory data bus between three requesters: instruction fetch (0), data access via register address (1), and external loader/debug port (2).
- Grants one requester at a time using round-robin priority.
- Sequences each transfer as SETUP, then ACCESS, then RECOVER, driving the memory chip-level strobes.
- Replaces the hard-wired "PC always asserts address bus, memory always asserts data bus" arrangement.

Parameters:
- ACCESS_CYCLES, 2, cycles in ACCESS state with strobe asserted; legal range 1..15.
- DELAY_RISE, 0, rise delay applied to all registered outputs.
- DELAY_FALL, 0, fall delay applied to all registered outputs.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  3  per-requester request; bit n = requester n.
- WE  in  3  per-requester write flag (1 = write, 0 = read); must be stable while REQ is high.
- ADDR_0, ADDR_1, ADDR_2  in  16 each  requester addresses; stable while REQ is high.
- WDATA_0, WDATA_1, WDATA_2  in  8 each  requester write data.
- ACK  out  3  one-cycle completion pulse to the granted requester.
- RDATA  out  8  read data; valid while ACK is high, then held until the next read completes.
- MEM_ADDR  out  16  memory address.
- MEM_DATA_OUT  out  8  write data toward memory.
- MEM_DATA_OE  out  1  high = arbiter drives the memory data bus.
- MEM_DATA_IN  in  8  memory data bus read value.
- MEM_OE_bar  out  1  memory output enable, active low.
- MEM_WE_bar  out  1  memory write enable, active low.
- BUSY  out  1  high in any state other than IDLE.
- GRANT_INDEX  out  2  index of the current or last granted requester.

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; ACK = 0; RDATA = 0x00; MEM_ADDR = 0x0000; MEM_DATA_OUT = 0x00; MEM_DATA_OE = 0; MEM_OE_bar = 1; MEM_WE_bar = 1; BUSY = 0; GRANT_INDEX = 0; round-robin pointer LAST = 2, so requester 0 has top priority first.
- IDLE:
  - REQ is sampled only in this state.
  - If REQ != 0, the winner is the first set bit scanning LAST+1, LAST+2, LAST+3 (mod 3).
  - On winning, latch the winner's ADDR/WE/WDATA and set GRANT_INDEX; go to SETUP.
  - If REQ == 0, stay in IDLE.
- SETUP (1 cycle):
  - MEM_ADDR = latched address; strobes high.
  - If write, MEM_DATA_OE = 1 and MEM_DATA_OUT = WDATA.
  - Load counter with ACCESS_CYCLES-1; go to ACCESS.
- ACCESS (ACCESS_CYCLES cycles):
  - Read: MEM_OE_bar = 0. Write: MEM_WE_bar = 0.
  - Counter decrements each cycle.
  - When counter == 0: on a read, capture MEM_DATA_IN into RDATA at that edge; go to RECOVER.
- RECOVER (1 cycle):
  - Both strobes high; MEM_ADDR held; MEM_DATA_OE stays high on writes (hold time).
  - ACK[GRANT_INDEX] = 1; LAST = GRANT_INDEX; go to IDLE.
  - Leaving RECOVER: MEM_DATA_OE = 0 and ACK = 0.
- Latency: REQ first seen in IDLE at edge k gives ACK high during cycle k+ACCESS_CYCLES+2. Back-to-back transfers have a throughput of one per ACCESS_CYCLES+3 cycles.
- Requester rule: drop REQ, or present the next transfer, on the edge where ACK is seen. A REQ still high in IDLE is treated as a new transfer.
- REQ changes while not in IDLE are ignored. A requester deasserting REQ mid-transfer does not abort it; ACK still pulses.
- Never more than one ACK bit high. MEM_OE_bar and MEM_WE_bar are never low together.
- RST mid-transfer: at the next edge all outputs return to reset values and no ACK is issued. The aborted requester must re-request.
- Counter width is 4 bits.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE, ST_SETUP, ST_ACCESS, ST_RECOVER.
  - Requester index constants REQ_FETCH = 0, REQ_DATA = 1, REQ_EXT = 2.
- One combinational sub-module, rr_pick3: inputs REQ[2:0] and LAST[1:0]; outputs VALID and WINNER[1:0].
- The top level holds the FSM, counter, latches and output registers.

Test Plan:
- Reset, then single read with REQ = 001, ADDR_0 = 0x1234, MEM_DATA_IN = 0xA5, ACCESS_CYCLES = 2:
  - MEM_ADDR = 0x1234 from SETUP.
  - MEM_OE_bar low for exactly 2 cycles.
  - ACK = 001 in the 4th cycle after the sampling edge, with RDATA = 0xA5.
- Write with REQ = 010, WE = 010, ADDR_1 = 0x8001, WDATA_1 = 0x3C:
  - MEM_DATA_OE high across SETUP, ACCESS and RECOVER; MEM_DATA_OUT = 0x3C.
  - MEM_WE_bar low for 2 cycles; MEM_OE_bar stays high.
  - ACK = 010; RDATA unchanged.
- All requesters held requesting (REQ = 111, each re-asserting after its ACK):
  - Grants in order 0, 1, 2, 0, 1, 2.
  - Exactly one ACK bit per transfer; BUSY drops for exactly one IDLE cycle between transfers.
- Starvation check: requester 0 re-requests immediately while 2 waits. Requester 2 is granted no later than the third transfer.
- RST pulsed in the 1st ACCESS cycle of a write:
  - Next cycle MEM_WE_bar = 1, MEM_DATA_OE = 0, state IDLE, no ACK.
  - Next grant goes to requester 0.
- Run with ACCESS_CYCLES = 1 and 15: strobe width equals the parameter and ACK latency equals parameter+2.
